jzjpcc_decode: RTL and testbench

Decode stage of the jzjpcc pipelined RV32I core, between fetch and execute. Takes the fetched instruction word and PC, reads the register file, and generates immediates and control signals. It resolves all control transfers (JAL, JALR, branches) within decode, drives the fetch redirect, flush and stall signals, and registers the decoded instruction into the execute-stage pipeline register.

---
 rtl/jzjpcc_decode.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_jzjpcc_decode.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jzjpcc_decode.sv
// jzjpcc RV32I decode stage: register read, immediate and control generation,
// in-decode control-transfer resolution, hazard stalls and the execute pipeline register.
module jzjpcc_decode #(
    parameter int PC_MAX_B = 13
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:2]         instruction_decode,
    input  logic [PC_MAX_B:2]   currentPC_decode,
    output logic [4:0]          rs1Addr_decode,
    output logic [4:0]          rs2Addr_decode,
    input  logic [31:0]         rs1_decode,
    input  logic [31:0]         rs2_decode,
    output logic [4:0]          rdAddr_execute,
    output logic                rdWriteEnable_execute,
    output logic                memRead_execute,
    input  logic [4:0]          rdAddr_memory,
    input  logic                rdWriteEnable_memory,
    input  logic                memRead_memory,
    input  logic [31:0]         aluResult_memory,
    output logic                pcCTWriteEnable,
    output logic [PC_MAX_B:2]   controlTransferNewPC,
    output logic                stall_fetch,
    output logic                flush_decode,
    output logic [4:0]          opcode_execute,
    output logic [2:0]          funct3_execute,
    output logic                funct7b5_execute,
    output logic [31:0]         immediate_execute,
    output logic [31:0]         rs1_execute,
    output logic [31:0]         rs2_execute,
    output logic [4:0]          rs1Addr_execute,
    output logic [4:0]          rs2Addr_execute,
    output logic [PC_MAX_B:2]   pc_execute,
    output logic                memWrite_execute,
    output logic                illegalInstruction
);

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_FENCE  = 5'b00011;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    logic [4:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [31:0] w_immI;
    logic [31:0] w_immS;
    logic [31:0] w_immB;
    logic [31:0] w_immU;
    logic [31:0] w_immJ;

    logic [31:0] w_imm;
    logic        w_rdWE;
    logic        w_memRead;
    logic        w_memWrite;
    logic        w_useRs1;
    logic        w_useRs2;
    logic        w_isBranch;
    logic        w_isJal;
    logic        w_isJalr;
    logic        w_illegal;

    logic [31:0] w_rs1Fwd;
    logic [31:0] w_rs2Fwd;
    logic        w_loadUse;
    logic        w_ctExHazard;
    logic        w_ctMemHazard;
    logic        w_stall;
    logic        w_branchCond;
    logic        w_taken;
    logic [31:0] w_pcByte;
    logic [31:0] w_target;
    logic        w_unused;

    logic [4:0]          r_rd;
    logic                r_rdWE;
    logic                r_memRead;
    logic                r_memWrite;
    logic [4:0]          r_opcode;
    logic [2:0]          r_funct3;
    logic                r_funct7b5;
    logic [31:0]         r_imm;
    logic [31:0]         r_rs1;
    logic [31:0]         r_rs2;
    logic [4:0]          r_rs1Addr;
    logic [4:0]          r_rs2Addr;
    logic [PC_MAX_B:2]   r_pc;
    logic                r_illegal;

    assign w_opcode = instruction_decode[6:2];
    assign w_rd     = instruction_decode[11:7];
    assign w_funct3 = instruction_decode[14:12];
    assign w_rs1    = instruction_decode[19:15];
    assign w_rs2    = instruction_decode[24:20];

    assign rs1Addr_decode = w_rs1;
    assign rs2Addr_decode = w_rs2;

    assign w_immI = {{20{instruction_decode[31]}}, instruction_decode[31:20]};
    assign w_immS = {{20{instruction_decode[31]}}, instruction_decode[31:25], instruction_decode[11:7]};
    assign w_immB = {{19{instruction_decode[31]}}, instruction_decode[31], instruction_decode[7],
                     instruction_decode[30:25], instruction_decode[11:8], 1'b0};
    assign w_immU = {instruction_decode[31:12], 12'h000};
    assign w_immJ = {{11{instruction_decode[31]}}, instruction_decode[31], instruction_decode[19:12],
                     instruction_decode[20], instruction_decode[30:21], 1'b0};

    always_comb begin
        w_imm      = '0;
        w_rdWE     = 1'b0;
        w_memRead  = 1'b0;
        w_memWrite = 1'b0;
        w_useRs1   = 1'b0;
        w_useRs2   = 1'b0;
        w_isBranch = 1'b0;
        w_isJal    = 1'b0;
        w_isJalr   = 1'b0;
        w_illegal  = 1'b0;
        case (w_opcode)
            OP_LOAD: begin
                w_imm     = w_immI;
                w_rdWE    = 1'b1;
                w_memRead = 1'b1;
                w_useRs1  = 1'b1;
            end
            OP_OPIMM: begin
                w_imm    = w_immI;
                w_rdWE   = 1'b1;
                w_useRs1 = 1'b1;
            end
            OP_AUIPC, OP_LUI: begin
                w_imm  = w_immU;
                w_rdWE = 1'b1;
            end
            OP_STORE: begin
                w_imm      = w_immS;
                w_memWrite = 1'b1;
                w_useRs1   = 1'b1;
                w_useRs2   = 1'b1;
            end
            OP_OP: begin
                w_rdWE   = 1'b1;
                w_useRs1 = 1'b1;
                w_useRs2 = 1'b1;
            end
            OP_BRANCH: begin
                w_imm      = w_immB;
                w_useRs1   = 1'b1;
                w_useRs2   = 1'b1;
                w_isBranch = 1'b1;
                w_illegal  = (w_funct3[2:1] == 2'b01);
            end
            OP_JALR: begin
                w_imm    = w_immI;
                w_rdWE   = 1'b1;
                w_useRs1 = 1'b1;
                w_isJalr = 1'b1;
            end
            OP_JAL: begin
                w_imm   = w_immJ;
                w_rdWE  = 1'b1;
                w_isJal = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: ;
            default: w_illegal = 1'b1;
        endcase
        if (w_rd == 5'd0) w_rdWE = 1'b0;
    end

    // Loads in memory cannot forward; their hazard is covered by the stall logic.
    assign w_rs1Fwd = (rdWriteEnable_memory && !memRead_memory && (rdAddr_memory == w_rs1) && (w_rs1 != 5'd0))
                      ? aluResult_memory : rs1_decode;
    assign w_rs2Fwd = (rdWriteEnable_memory && !memRead_memory && (rdAddr_memory == w_rs2) && (w_rs2 != 5'd0))
                      ? aluResult_memory : rs2_decode;

    assign w_loadUse = r_memRead && r_rdWE && (r_rd != 5'd0) &&
                       ((w_useRs1 && (w_rs1 == r_rd)) || (w_useRs2 && (w_rs2 == r_rd)));
    assign w_ctExHazard = (w_isBranch || w_isJalr) && r_rdWE && (r_rd != 5'd0) &&
                          ((w_rs1 == r_rd) || (w_isBranch && (w_rs2 == r_rd)));
    assign w_ctMemHazard = (w_isBranch || w_isJalr) && memRead_memory && (rdAddr_memory != 5'd0) &&
                           ((w_rs1 == rdAddr_memory) || (w_isBranch && (w_rs2 == rdAddr_memory)));
    assign w_stall = w_loadUse || w_ctExHazard || w_ctMemHazard;

    always_comb begin
        w_branchCond = 1'b0;
        case (w_funct3)
            3'b000:  w_branchCond = (w_rs1Fwd == w_rs2Fwd);
            3'b001:  w_branchCond = (w_rs1Fwd != w_rs2Fwd);
            3'b100:  w_branchCond = ($signed(w_rs1Fwd) <  $signed(w_rs2Fwd));
            3'b101:  w_branchCond = ($signed(w_rs1Fwd) >= $signed(w_rs2Fwd));
            3'b110:  w_branchCond = (w_rs1Fwd <  w_rs2Fwd);
            3'b111:  w_branchCond = (w_rs1Fwd >= w_rs2Fwd);
            default: w_branchCond = 1'b0;
        endcase
    end

    assign w_pcByte = 32'({currentPC_decode, 2'b00});
    assign w_target = w_isJalr ? ((w_rs1Fwd + w_imm) & ~32'd1) : (w_pcByte + w_imm);
    assign w_taken  = !w_stall && (w_isJal || w_isJalr || (w_isBranch && w_branchCond));

    // Byte-offset bits and bits above the PC range are dropped by design.
    assign w_unused = ^{w_target[31:PC_MAX_B+1], w_target[1:0]};

    assign pcCTWriteEnable      = w_taken;
    assign flush_decode         = w_taken;
    assign stall_fetch          = w_stall;
    assign controlTransferNewPC = w_target[PC_MAX_B:2];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd       <= '0;
            r_rdWE     <= 1'b0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_opcode   <= '0;
            r_funct3   <= '0;
            r_funct7b5 <= 1'b0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rs1Addr  <= '0;
            r_rs2Addr  <= '0;
            r_pc       <= '0;
            r_illegal  <= 1'b0;
        end else if (w_stall) begin
            r_rd       <= '0;
            r_rdWE     <= 1'b0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_opcode   <= OP_OPIMM;
            r_funct3   <= '0;
            r_funct7b5 <= 1'b0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rs1Addr  <= '0;
            r_rs2Addr  <= '0;
            r_pc       <= '0;
        end else begin
            r_rd       <= w_rd;
            r_rdWE     <= w_rdWE;
            r_memRead  <= w_memRead;
            r_memWrite <= w_memWrite;
            r_opcode   <= w_opcode;
            r_funct3   <= w_funct3;
            r_funct7b5 <= instruction_decode[30];
            r_imm      <= w_imm;
            r_rs1      <= w_rs1Fwd;
            r_rs2      <= w_rs2Fwd;
            r_rs1Addr  <= w_rs1;
            r_rs2Addr  <= w_rs2;
            r_pc       <= currentPC_decode;
            if (w_illegal) r_illegal <= 1'b1;
        end
    end

    assign rdAddr_execute        = r_rd;
    assign rdWriteEnable_execute = r_rdWE;
    assign memRead_execute       = r_memRead;
    assign memWrite_execute      = r_memWrite;
    assign opcode_execute        = r_opcode;
    assign funct3_execute        = r_funct3;
    assign funct7b5_execute      = r_funct7b5;
    assign immediate_execute     = r_imm;
    assign rs1_execute           = r_rs1;
    assign rs2_execute           = r_rs2;
    assign rs1Addr_execute       = r_rs1Addr;
    assign rs2Addr_execute       = r_rs2Addr;
    assign pc_execute            = r_pc;
    assign illegalInstruction    = r_illegal;

endmodule

// File: tb/tb_jzjpcc_decode.sv
// Directed bench for jzjpcc_decode: instruction-level model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_jzjpcc_decode;

    localparam int PCB = 13;
    localparam logic [31:0] NOP = 32'h00000013;

    logic              clock;
    logic              reset;
    logic [31:2]       instruction_decode;
    logic [PCB:2]      currentPC_decode;
    logic [4:0]        rs1Addr_decode, rs2Addr_decode;
    logic [31:0]       rs1_decode, rs2_decode;
    logic [4:0]        rdAddr_execute;
    logic              rdWriteEnable_execute, memRead_execute;
    logic [4:0]        rdAddr_memory;
    logic              rdWriteEnable_memory, memRead_memory;
    logic [31:0]       aluResult_memory;
    logic              pcCTWriteEnable;
    logic [PCB:2]      controlTransferNewPC;
    logic              stall_fetch, flush_decode;
    logic [4:0]        opcode_execute;
    logic [2:0]        funct3_execute;
    logic              funct7b5_execute;
    logic [31:0]       immediate_execute, rs1_execute, rs2_execute;
    logic [4:0]        rs1Addr_execute, rs2Addr_execute;
    logic [PCB:2]      pc_execute;
    logic              memWrite_execute, illegalInstruction;

    jzjpcc_decode #(.PC_MAX_B(PCB)) dut (
        .clock(clock), .reset(reset),
        .instruction_decode(instruction_decode), .currentPC_decode(currentPC_decode),
        .rs1Addr_decode(rs1Addr_decode), .rs2Addr_decode(rs2Addr_decode),
        .rs1_decode(rs1_decode), .rs2_decode(rs2_decode),
        .rdAddr_execute(rdAddr_execute), .rdWriteEnable_execute(rdWriteEnable_execute),
        .memRead_execute(memRead_execute),
        .rdAddr_memory(rdAddr_memory), .rdWriteEnable_memory(rdWriteEnable_memory),
        .memRead_memory(memRead_memory), .aluResult_memory(aluResult_memory),
        .pcCTWriteEnable(pcCTWriteEnable), .controlTransferNewPC(controlTransferNewPC),
        .stall_fetch(stall_fetch), .flush_decode(flush_decode),
        .opcode_execute(opcode_execute), .funct3_execute(funct3_execute),
        .funct7b5_execute(funct7b5_execute), .immediate_execute(immediate_execute),
        .rs1_execute(rs1_execute), .rs2_execute(rs2_execute),
        .rs1Addr_execute(rs1Addr_execute), .rs2Addr_execute(rs2Addr_execute),
        .pc_execute(pc_execute), .memWrite_execute(memWrite_execute),
        .illegalInstruction(illegalInstruction)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    logic chk_en;
    logic [31:0] instr;
    logic [31:0] regs [32];

    assign instruction_decode = instr[31:2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    typedef enum logic [2:0] {F_I, F_S, F_B, F_U, F_J, F_R, F_N, F_X} fmt_t;
    typedef struct packed {
        logic [4:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] imm;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  rd;
        logic [11:0] pc;
        logic        we;
        logic        mr;
        logic        mw;
        logic        bub;
    } ex_t;

    ex_t         m_ex, m_nx;
    logic        m_ill;
    fmt_t        fmt;
    logic [31:0] m_imm, f1, f2, target;
    logic        m_stall, m_taken, m_bad, cond, wr;
    logic        use1, use2, ctl, isb;
    logic [4:0]  op, rd, a1, a2;
    logic [2:0]  f3;

    always @* begin
        op = instr[6:2]; rd = instr[11:7]; f3 = instr[14:12];
        a1 = instr[19:15]; a2 = instr[24:20];
        case (op)
            5'b00000, 5'b00100, 5'b11001: fmt = F_I;
            5'b01000:                     fmt = F_S;
            5'b11000:                     fmt = F_B;
            5'b01101, 5'b00101:           fmt = F_U;
            5'b11011:                     fmt = F_J;
            5'b01100:                     fmt = F_R;
            5'b00011, 5'b11100:           fmt = F_N;
            default:                      fmt = F_X;
        endcase
        case (fmt)
            F_I:     m_imm = {{20{instr[31]}}, instr[31:20]};
            F_S:     m_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            F_B:     m_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            F_U:     m_imm = {instr[31:12], 12'h000};
            F_J:     m_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: m_imm = 32'h0;
        endcase
        wr   = (op inside {5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b00000, 5'b00100, 5'b01100}) && (rd != 0);
        use1 = fmt inside {F_I, F_S, F_B, F_R};
        use2 = fmt inside {F_S, F_B, F_R};
        isb  = (op == 5'b11000);
        ctl  = isb || (op == 5'b11001);
        f1 = (rdWriteEnable_memory && !memRead_memory && rdAddr_memory == a1 && a1 != 0) ? aluResult_memory : rs1_decode;
        f2 = (rdWriteEnable_memory && !memRead_memory && rdAddr_memory == a2 && a2 != 0) ? aluResult_memory : rs2_decode;
        m_stall = (m_ex.mr && m_ex.we && m_ex.rd != 0 && ((use1 && a1 == m_ex.rd) || (use2 && a2 == m_ex.rd)))
               || (ctl && m_ex.we && m_ex.rd != 0 && (a1 == m_ex.rd || (isb && a2 == m_ex.rd)))
               || (ctl && memRead_memory && rdAddr_memory != 0 && (a1 == rdAddr_memory || (isb && a2 == rdAddr_memory)));
        case (f3)
            3'd0:    cond = (f1 == f2);
            3'd1:    cond = (f1 != f2);
            3'd4:    cond = ($signed(f1) < $signed(f2));
            3'd5:    cond = ($signed(f1) >= $signed(f2));
            3'd6:    cond = (f1 < f2);
            3'd7:    cond = (f1 >= f2);
            default: cond = 1'b0;
        endcase
        m_taken = !m_stall && ((op == 5'b11011) || (op == 5'b11001) || (isb && cond));
        if (op == 5'b11001) target = (f1 + m_imm) & 32'hFFFFFFFE;
        else                target = {18'h0, currentPC_decode, 2'b00} + m_imm;
        m_bad = (fmt == F_X) || (isb && (f3 == 3'd2 || f3 == 3'd3));
        m_nx = '0;
        if (m_stall) begin
            m_nx.op  = 5'b00100;
            m_nx.bub = 1'b1;
        end else begin
            m_nx.op = op; m_nx.f3 = f3; m_nx.f7 = instr[30]; m_nx.imm = m_imm;
            m_nx.v1 = f1; m_nx.v2 = f2; m_nx.a1 = a1; m_nx.a2 = a2; m_nx.rd = rd;
            m_nx.pc = currentPC_decode; m_nx.we = wr;
            m_nx.mr = (op == 5'b00000); m_nx.mw = (op == 5'b01000);
        end
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_ex  <= '0;
            m_ill <= 1'b0;
        end else begin
            m_ex <= m_nx;
            if (!m_stall && m_bad) m_ill <= 1'b1;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("m_stall", {31'h0, stall_fetch}, {31'h0, m_stall});
            chk("m_pcct", {31'h0, pcCTWriteEnable}, {31'h0, m_taken});
            chk("m_flush", {31'h0, flush_decode}, {31'h0, m_taken});
            chk("m_rs1a", {27'h0, rs1Addr_decode}, {27'h0, instr[19:15]});
            chk("m_rs2a", {27'h0, rs2Addr_decode}, {27'h0, instr[24:20]});
            if (m_taken) chk("m_npc", {20'h0, controlTransferNewPC}, {20'h0, target[13:2]});
            chk("m_ill", {31'h0, illegalInstruction}, {31'h0, m_ill});
            chk("m_op", {27'h0, opcode_execute}, {27'h0, m_ex.op});
            chk("m_rd", {27'h0, rdAddr_execute}, {27'h0, m_ex.rd});
            chk("m_we", {31'h0, rdWriteEnable_execute}, {31'h0, m_ex.we});
            chk("m_mr", {31'h0, memRead_execute}, {31'h0, m_ex.mr});
            chk("m_mw", {31'h0, memWrite_execute}, {31'h0, m_ex.mw});
            if (!m_ex.bub) begin
                chk("m_f3", {29'h0, funct3_execute}, {29'h0, m_ex.f3});
                chk("m_f7", {31'h0, funct7b5_execute}, {31'h0, m_ex.f7});
                chk("m_imm", immediate_execute, m_ex.imm);
                chk("m_v1", rs1_execute, m_ex.v1);
                chk("m_v2", rs2_execute, m_ex.v2);
                chk("m_a1", {27'h0, rs1Addr_execute}, {27'h0, m_ex.a1});
                chk("m_a2", {27'h0, rs2Addr_execute}, {27'h0, m_ex.a2});
                chk("m_pc", {20'h0, pc_execute}, {20'h0, m_ex.pc});
            end
        end
    end

    // ---------------- encoders and stimulus ----------------
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction
    function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
        return {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [11:0] pcw);
        instr            = ins;
        currentPC_decode = pcw;
        rs1_decode       = regs[ins[19:15]];
        rs2_decode       = regs[ins[24:20]];
    endtask

    task automatic set_mem(input logic we, input logic mr, input logic [4:0] rda, input logic [31:0] alu);
        rdWriteEnable_memory = we;
        memRead_memory       = mr;
        rdAddr_memory        = rda;
        aluResult_memory     = alu;
    endtask

    task automatic next();
        @(posedge clock);
        #2;
    endtask

    initial begin
        chk_en = 1'b0;
        reset  = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[1] = 32'd3; regs[2] = 32'd99; regs[9] = 32'h21;
        set_mem(1'b0, 1'b0, 5'd0, 32'h0);
        drive(NOP, 12'd0);
        #1 reset = 1'b0;
        #1 chk_en = 1'b1;

        next(); #1;
        chk("rst_op", {27'h0, opcode_execute}, 32'h0);
        chk("rst_we", {31'h0, rdWriteEnable_execute}, 32'h0);
        chk("rst_ill", {31'h0, illegalInstruction}, 32'h0);

        next(); reset = 1'b1; drive(NOP, 12'd0); #1;
        chk("rel_imm", immediate_execute, 32'h0);
        chk("rel_pc", {20'h0, pc_execute}, 32'h0);

        next(); drive(enc_i(12'hFFF, 5'd0, 3'b000, 5'd5, 7'b0010011), 12'd4); #1;
        chk("nop_op", {27'h0, opcode_execute}, 32'h4);
        chk("nop_we", {31'h0, rdWriteEnable_execute}, 32'h0);
        chk("addi_stall", {31'h0, stall_fetch}, 32'h0);
        chk("addi_pcct", {31'h0, pcCTWriteEnable}, 32'h0);

        next(); drive(enc_i(12'h000, 5'd2, 3'b010, 5'd6, 7'b0000011), 12'd5); #1;
        chk("addi_imm", immediate_execute, 32'hFFFFFFFF);
        chk("addi_rd", {27'h0, rdAddr_execute}, 32'd5);
        chk("addi_we", {31'h0, rdWriteEnable_execute}, 32'h1);
        chk("addi_pc", {20'h0, pc_execute}, 32'd4);

        next(); drive(enc_r(5'd1, 5'd6, 5'd7), 12'd6); #1;
        chk("lu_stall", {31'h0, stall_fetch}, 32'h1);
        next(); drive(enc_r(5'd1, 5'd6, 5'd7), 12'd6); #1;
        chk("lu_bub_op", {27'h0, opcode_execute}, 32'h4);
        chk("lu_bub_we", {31'h0, rdWriteEnable_execute}, 32'h0);
        chk("lu_release", {31'h0, stall_fetch}, 32'h0);

        next(); set_mem(1'b1, 1'b0, 5'd2, 32'd3); drive(enc_b(13'd16, 5'd2, 5'd1, 3'b000), 12'd8); #1;
        chk("add_rd", {27'h0, rdAddr_execute}, 32'd7);
        chk("add_we", {31'h0, rdWriteEnable_execute}, 32'h1);
        chk("beq_pcct", {31'h0, pcCTWriteEnable}, 32'h1);
        chk("beq_flush", {31'h0, flush_decode}, 32'h1);
        chk("beq_npc", {20'h0, controlTransferNewPC}, 32'd12);

        next(); set_mem(1'b1, 1'b0, 5'd2, 32'd4); drive(enc_b(13'd16, 5'd2, 5'd1, 3'b000), 12'd8); #1;
        chk("beq_fwd_v2", rs2_execute, 32'd3);
        chk("beqn_pcct", {31'h0, pcCTWriteEnable}, 32'h0);

        next(); set_mem(1'b0, 1'b0, 5'd0, 32'h0); drive(enc_i(12'hFFD, 5'd9, 3'b000, 5'd1, 7'b1100111), 12'd10); #1;
        chk("jalr_pcct", {31'h0, pcCTWriteEnable}, 32'h1);
        chk("jalr_npc", {20'h0, controlTransferNewPC}, 32'd7);

        next(); drive(enc_j(21'h1FFFF8, 5'd1), 12'd0); #1;
        chk("jalr_imm", immediate_execute, 32'hFFFFFFFD);
        chk("jalr_we", {31'h0, rdWriteEnable_execute}, 32'h1);
        chk("jal_npc", {20'h0, controlTransferNewPC}, 32'hFFE);

        next(); drive(enc_i(12'd4, 5'd0, 3'b010, 5'd3, 7'b0000011), 12'd20); #1;
        chk("jal_imm", immediate_execute, 32'hFFFFFFF8);
        next(); drive(enc_b(13'd8, 5'd0, 5'd3, 3'b000), 12'd21); #1;
        chk("bl_stall1", {31'h0, stall_fetch}, 32'h1);
        next(); set_mem(1'b1, 1'b1, 5'd3, 32'h0); drive(enc_b(13'd8, 5'd0, 5'd3, 3'b000), 12'd21); #1;
        chk("bl_stall2", {31'h0, stall_fetch}, 32'h1);
        next(); set_mem(1'b0, 1'b0, 5'd0, 32'h0); drive(enc_b(13'd8, 5'd0, 5'd3, 3'b000), 12'd21); #1;
        chk("bl_go", {31'h0, stall_fetch}, 32'h0);
        chk("bl_npc", {20'h0, controlTransferNewPC}, 32'd23);

        next(); drive(enc_s(12'd8, 5'd5, 5'd2), 12'd24);
        next(); drive(enc_u(20'h12345, 5'd10, 7'b0110111), 12'd25); #1;
        chk("sw_mw", {31'h0, memWrite_execute}, 32'h1);
        chk("sw_imm", immediate_execute, 32'd8);
        next(); drive(enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011), 12'd26); #1;
        chk("lui_imm", immediate_execute, 32'h12345000);

        regs[1] = 32'hFFFFFFFF; regs[2] = 32'd1;
        next(); drive(enc_b(13'd12, 5'd2, 5'd1, 3'b100), 12'd27); #1;
        chk("x0_we", {31'h0, rdWriteEnable_execute}, 32'h0);
        chk("blt_npc", {20'h0, controlTransferNewPC}, 32'd30);
        next(); drive(enc_b(13'd12, 5'd2, 5'd1, 3'b110), 12'd27); #1;
        chk("bltu_pcct", {31'h0, pcCTWriteEnable}, 32'h0);

        next(); drive(32'h0000007F, 12'd28); #1;
        chk("ill_before", {31'h0, illegalInstruction}, 32'h0);
        next(); drive(enc_i(12'd1, 5'd0, 3'b000, 5'd5, 7'b0010011), 12'd29); #1;
        chk("ill_set", {31'h0, illegalInstruction}, 32'h1);
        next(); drive(NOP, 12'd30); #1;
        chk("ill_sticky", {31'h0, illegalInstruction}, 32'h1);

        next(); drive(enc_i(12'h000, 5'd2, 3'b010, 5'd6, 7'b0000011), 12'd30);
        next(); drive(enc_r(5'd1, 5'd6, 5'd7), 12'd31); #1;
        chk("mid_stall", {31'h0, stall_fetch}, 32'h1);
        reset = 1'b0; #1;
        chk("mrst_op", {27'h0, opcode_execute}, 32'h0);
        chk("mrst_mr", {31'h0, memRead_execute}, 32'h0);
        chk("mrst_ill", {31'h0, illegalInstruction}, 32'h0);
        chk("mrst_stall", {31'h0, stall_fetch}, 32'h0);
        next(); drive(NOP, 12'd0);
        next(); reset = 1'b1;
        next(); next();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
